// File: rtl/ee_access_ctrl.sv
// ee_access_ctrl
//   Baseband-side initiator for the S018EE1KX16 EEPROM macro (64 x 16).
//   Turns single-word read/write requests into CEN/OEN/WEN/A/DBI/RD_CLK
//   sequencing, captures DBO on reads, and tracks the READY busy window on
//   writes. Every output is a flop, so WEN and RD_CLK cannot glitch.
//
// Ports
//   CLK1D92, RSTN       : 1.92 MHz clock, async active-low reset
//   req_rd, req_wr      : single-word requests, sampled only in IDLE (write wins)
//   req_addr, req_wdata : request address / write data
//   busy                : FSM is not in IDLE
//   rdata, rdata_vld    : captured read word / one-cycle update pulse
//   wr_done, wr_err     : write completion pulse / timeout flag (with wr_done)
//   A, CEN, OEN, WEN    : macro address and active-low strobes
//   DBI, RD_CLK         : macro write data / read clock
//   DBO, READY          : macro read data / write-ready (low = programming)

module ee_access_ctrl #(
    parameter int unsigned AW       = 6,
    parameter int unsigned DW       = 16,
    parameter int unsigned FALL_WIN = 511,
    parameter int unsigned BUSY_MAX = 16383
) (
    input  logic          CLK1D92,
    input  logic          RSTN,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    output logic          wr_done,
    output logic          wr_err,
    output logic [AW-1:0] A,
    output logic          CEN,
    output logic          OEN,
    output logic          WEN,
    output logic [DW-1:0] DBI,
    output logic          RD_CLK,
    input  logic [DW-1:0] DBO,
    input  logic          READY
);

    localparam int unsigned CW = 14;
    localparam logic [CW-1:0] FALL_WIN_C = CW'(FALL_WIN);
    localparam logic [CW-1:0] BUSY_MAX_C = CW'(BUSY_MAX);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RD_SET   = 4'd1;
    localparam logic [3:0] S_RD_CLK_H = 4'd2;
    localparam logic [3:0] S_RD_CAP   = 4'd3;
    localparam logic [3:0] S_WR_SET   = 4'd4;
    localparam logic [3:0] S_WR_PULSE = 4'd5;
    localparam logic [3:0] S_WR_WLOW  = 4'd6;
    localparam logic [3:0] S_WR_WHIGH = 4'd7;
    localparam logic [3:0] S_WR_END   = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] dbi_q, dbi_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          cen_q, cen_d;
    logic          oen_q, oen_d;
    logic          wen_q, wen_d;
    logic          rdclk_q, rdclk_d;
    logic          rdata_vld_q, rdata_vld_d;
    logic          wr_done_q, wr_done_d;
    logic          wr_err_q, wr_err_d;
    logic          tmo_q, tmo_d;

    // Saturating increment: the counter never wraps past BUSY_MAX.
    assign cnt_inc = (cnt_q == BUSY_MAX_C) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        dbi_d       = dbi_q;
        rdata_d     = rdata_q;
        cen_d       = cen_q;
        oen_d       = oen_q;
        wen_d       = wen_q;
        rdclk_d     = rdclk_q;
        rdata_vld_d = 1'b0;
        wr_done_d   = 1'b0;
        wr_err_d    = 1'b0;
        tmo_d       = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (req_wr) begin
                    a_d     = req_addr;
                    dbi_d   = req_wdata;
                    cen_d   = 1'b0;
                    oen_d   = 1'b1;
                    tmo_d   = 1'b0;
                    state_d = S_WR_SET;
                end else if (req_rd) begin
                    a_d     = req_addr;
                    cen_d   = 1'b0;
                    oen_d   = 1'b0;
                    state_d = S_RD_SET;
                end
            end
            S_RD_SET: begin
                rdclk_d = 1'b1;
                state_d = S_RD_CLK_H;
            end
            S_RD_CLK_H: begin
                rdclk_d = 1'b0;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                rdata_d     = DBO;
                rdata_vld_d = 1'b1;
                cen_d       = 1'b1;
                oen_d       = 1'b1;
                state_d     = S_IDLE;
            end
            S_WR_SET: begin
                wen_d   = 1'b0;
                state_d = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                wen_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_WR_WLOW;
            end
            // Waiting for the macro to start programming; a write that never
            // drops READY within the window is taken as already complete.
            S_WR_WLOW: begin
                if (!READY) begin
                    cnt_d   = '0;
                    state_d = S_WR_WHIGH;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FALL_WIN_C) begin
                        state_d = S_WR_END;
                    end
                end
            end
            S_WR_WHIGH: begin
                cnt_d = cnt_inc;
                if (READY) begin
                    state_d = S_WR_END;
                end else if (cnt_inc == BUSY_MAX_C) begin
                    tmo_d   = 1'b1;
                    state_d = S_WR_END;
                end
            end
            S_WR_END: begin
                wr_done_d = 1'b1;
                wr_err_d  = tmo_q;
                cen_d     = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                cen_d   = 1'b1;
                oen_d   = 1'b1;
                wen_d   = 1'b1;
                rdclk_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK1D92 or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            dbi_q       <= '0;
            rdata_q     <= '0;
            cen_q       <= 1'b1;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            rdclk_q     <= 1'b0;
            rdata_vld_q <= 1'b0;
            wr_done_q   <= 1'b0;
            wr_err_q    <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            dbi_q       <= dbi_d;
            rdata_q     <= rdata_d;
            cen_q       <= cen_d;
            oen_q       <= oen_d;
            wen_q       <= wen_d;
            rdclk_q     <= rdclk_d;
            rdata_vld_q <= rdata_vld_d;
            wr_done_q   <= wr_done_d;
            wr_err_q    <= wr_err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;
    assign wr_done   = wr_done_q;
    assign wr_err    = wr_err_q;
    assign A         = a_q;
    assign CEN       = cen_q;
    assign OEN       = oen_q;
    assign WEN       = wen_q;
    assign DBI       = dbi_q;
    assign RD_CLK    = rdclk_q;

endmodule

// File: tb/tb_ee_access_ctrl.sv
// Bench for ee_access_ctrl: behavioural EEPROM macro model plus a scoreboard
// of expected read words / write completions with their expected cycle.
`timescale 1ns/1ps

module tb_ee_access_ctrl;

    logic        CLK1D92 = 1'b0;
    logic        RSTN = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        busy;
    logic [15:0] rdata;
    logic        rdata_vld;
    logic        wr_done;
    logic        wr_err;
    logic [5:0]  A;
    logic        CEN;
    logic        OEN;
    logic        WEN;
    logic [15:0] DBI;
    logic        RD_CLK;
    logic [15:0] DBO = '0;
    logic        READY;

    ee_access_ctrl dut (
        .CLK1D92   (CLK1D92),
        .RSTN      (RSTN),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .busy      (busy),
        .rdata     (rdata),
        .rdata_vld (rdata_vld),
        .wr_done   (wr_done),
        .wr_err    (wr_err),
        .A         (A),
        .CEN       (CEN),
        .OEN       (OEN),
        .WEN       (WEN),
        .DBI       (DBI),
        .RD_CLK    (RD_CLK),
        .DBO       (DBO),
        .READY     (READY)
    );

    always #5 CLK1D92 = ~CLK1D92;

    int cyc = 0;
    always @(posedge CLK1D92) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- EEPROM macro model ----------------
    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    int          ready_mode = 1;  // 0 normal, 1 never falls, 2 stuck low
    int          mcnt = -1;
    logic        wen_dly = 1'b1;

    always @(posedge RD_CLK) DBO <= mem[A];
    always @(negedge WEN) if (RSTN === 1'b1 && CEN === 1'b0) mem[A] <= DBI;

    // Normal mode: READY falls 301 cycles after WEN rise is seen, rises at 9000.
    always @(posedge CLK1D92) begin
        wen_dly <= WEN;
        if (ready_mode == 0 && WEN === 1'b1 && wen_dly === 1'b0) mcnt <= 0;
        else if (mcnt >= 0 && mcnt < 9000) mcnt <= mcnt + 1;
        else mcnt <= -1;
    end
    assign READY = (ready_mode == 2) ? 1'b0 :
                   (ready_mode == 0 && mcnt >= 301 && mcnt < 9000) ? 1'b0 : 1'b1;

    int rdclk_hi = 0;
    int wen_lo = 0;
    always @(negedge CLK1D92) begin
        if (RD_CLK === 1'b1) rdclk_hi++;
        if (WEN === 1'b0) wen_lo++;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge CLK1D92) begin
        if (RSTN === 1'b1 && (rdata_vld === 1'b1 || wr_done === 1'b1)) begin
            exp_t e;
            check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("kind_wr", 32'(wr_done), 32'(e.is_wr));
                check_eq("kind_rd", 32'(rdata_vld), 32'(!e.is_wr));
                if (e.is_wr) check_eq("wr_err", 32'(wr_err), 32'(e.err));
                else check_eq("rdata", 32'(rdata), 32'(e.data));
                if (e.cyc >= 0) check_eq("out_cycle", cyc, e.cyc);
                check_eq("busy_at_out", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK1D92);
            if (!busy) break;
        end
        check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_read(input logic [5:0] addr, input bit trace);
        exp_t e;
        int   n;
        @(negedge CLK1D92);
        req_rd   = 1'b1;
        req_addr = addr;
        n        = cyc + 1;
        e.is_wr = 1'b0; e.data = ref_mem[addr]; e.err = 1'b0; e.cyc = n + 3;
        sb.push_back(e);
        @(negedge CLK1D92);
        req_rd = 1'b0;
        if (trace) begin
            check_eq("rd_A", 32'(A), 32'(addr));
            check_eq("rd_CEN", 32'(CEN), 32'd0);
            check_eq("rd_OEN", 32'(OEN), 32'd0);
            check_eq("rd_RDCLK_n0", 32'(RD_CLK), 32'd0);
            check_eq("rd_busy_n0", 32'(busy), 32'd1);
            @(negedge CLK1D92);
            check_eq("rd_RDCLK_n1", 32'(RD_CLK), 32'd1);
            check_eq("rd_busy_n1", 32'(busy), 32'd1);
            @(negedge CLK1D92);
            check_eq("rd_RDCLK_n2", 32'(RD_CLK), 32'd0);
            check_eq("rd_busy_n2", 32'(busy), 32'd1);
        end
        wait_idle(10);
    endtask

    // off < 0: completion cycle not checked
    task automatic do_write(input logic [5:0] addr, input logic [15:0] data, input int mode,
                            input bit exp_err, input int off, input bit trace);
        exp_t e;
        int   n;
        ready_mode = mode;
        @(negedge CLK1D92);
        req_wr    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        n         = cyc + 1;
        e.is_wr = 1'b1; e.data = data; e.err = exp_err; e.cyc = (off < 0) ? -1 : n + off;
        sb.push_back(e);
        @(negedge CLK1D92);
        req_wr = 1'b0;
        if (trace) begin
            check_eq("wr_A", 32'(A), 32'(addr));
            check_eq("wr_DBI", 32'(DBI), 32'(data));
            check_eq("wr_CEN", 32'(CEN), 32'd0);
            check_eq("wr_OEN", 32'(OEN), 32'd1);
            check_eq("wr_WEN_n0", 32'(WEN), 32'd1);
            @(negedge CLK1D92);
            check_eq("wr_WEN_n1", 32'(WEN), 32'd0);
            @(negedge CLK1D92);
            check_eq("wr_WEN_n2", 32'(WEN), 32'd1);
            check_eq("wr_A_hold", 32'(A), 32'(addr));
        end
        wait_idle(20000);
        ref_mem[addr] = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_CEN"}, 32'(CEN), 32'd1);
        check_eq({tag, "_OEN"}, 32'(OEN), 32'd1);
        check_eq({tag, "_WEN"}, 32'(WEN), 32'd1);
        check_eq({tag, "_RDCLK"}, 32'(RD_CLK), 32'd0);
        check_eq({tag, "_A"}, 32'(A), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 16'hC000 | 16'(i);
            ref_mem[i] = 16'hC000 | 16'(i);
        end
        mem[8]     = 16'h0301;
        ref_mem[8] = 16'h0301;

        repeat (3) @(negedge CLK1D92);
        check_reset_outputs("rst");
        check_eq("rst_DBI", 32'(DBI), 32'd0);
        check_eq("rst_vld", 32'(rdata_vld), 32'd0);
        check_eq("rst_done", 32'(wr_done), 32'd0);
        check_eq("rst_err", 32'(wr_err), 32'd0);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK1D92);

        do_read(6'd8, 1'b1);

        ready_mode = 0;
        do_write(6'd40, 16'hA5A5, 0, 1'b0, 9005, 1'b1);
        do_read(6'd40, 1'b0);

        do_write(6'd5, 16'h1234, 1, 1'b0, 514, 1'b0);
        do_read(6'd5, 1'b0);

        do_write(6'd6, 16'hBEEF, 2, 1'b1, 16387, 1'b0);
        ready_mode = 1;
        do_read(6'd6, 1'b0);

        // Simultaneous rd+wr: write wins; a read pulsed while busy is ignored.
        begin
            exp_t e;
            int   n;
            ready_mode = 1;
            rdclk_hi   = 0;
            wen_lo     = 0;
            @(negedge CLK1D92);
            req_rd = 1'b1; req_wr = 1'b1; req_addr = 6'd12; req_wdata = 16'h5A0F;
            n = cyc + 1;
            e.is_wr = 1'b1; e.data = 16'h5A0F; e.err = 1'b0; e.cyc = n + 514;
            sb.push_back(e);
            @(negedge CLK1D92);
            req_rd = 1'b0; req_wr = 1'b0;
            @(negedge CLK1D92);
            req_rd = 1'b1; req_addr = 6'd8;
            @(negedge CLK1D92);
            req_rd = 1'b0;
            wait_idle(1000);
            ref_mem[12] = 16'h5A0F;
            check_eq("both_no_rdclk", rdclk_hi, 0);
            check_eq("both_wen_pulse", wen_lo, 1);
        end
        do_read(6'd12, 1'b0);

        // Reset while RD_CLK is high.
        @(negedge CLK1D92);
        req_rd = 1'b1; req_addr = 6'd8;
        @(negedge CLK1D92);
        req_rd = 1'b0;
        @(negedge CLK1D92);
        check_eq("pre_rst_RDCLK", 32'(RD_CLK), 32'd1);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("rst_rd");
        @(negedge CLK1D92);
        RSTN = 1'b1;

        // Reset while waiting for READY to rise.
        ready_mode = 2;
        @(negedge CLK1D92);
        req_wr = 1'b1; req_addr = 6'd20; req_wdata = 16'h0F0F;
        @(negedge CLK1D92);
        req_wr = 1'b0;
        repeat (10) @(negedge CLK1D92);
        ref_mem[20] = 16'h0F0F;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        check_eq("pre_rst_CEN", 32'(CEN), 32'd0);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("rst_wr");
        ready_mode = 1;
        @(negedge CLK1D92);
        RSTN = 1'b1;

        do_read(6'd40, 1'b1);
        do_read(6'd20, 1'b0);

        repeat (3) @(negedge CLK1D92);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ee_access_ctrl.md
Name: ee_access_ctrl

Overview:
- Baseband-side initiator for the S018EE1KX16 1Kx16 EEPROM macro (64 words x 16 bits).
- Turns single-word read/write requests from the tag command logic into the macro's CEN/OEN/WEN/A/DBI/RD_CLK sequencing.
- Captures DBO on reads; on writes, tracks the macro's READY busy window and reports completion or timeout.
- Sits between the command decoder and the EEPROM macro, clocked by the 1.92 MHz baseband clock.

Parameters:
- AW, 6, address width (64 words).
- DW, 16, data width.
- FALL_WIN, 511, cycles after WEN rise to wait for READY to go low; if it never falls, the write is treated as complete.
- BUSY_MAX, 16383, maximum cycles READY may stay low before a timeout is flagged.

Ports:
- CLK1D92  in  1  the single clock of the block (1.92 MHz).
- RSTN  in  1  asynchronous, active-low reset.
- req_rd  in  1  read request, sampled in IDLE.
- req_wr  in  1  write request, sampled in IDLE.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- busy  out  1  high whenever the FSM is not in IDLE.
- rdata  out  DW  captured read word, held until the next read.
- rdata_vld  out  1  one-cycle pulse when rdata updates.
- wr_done  out  1  one-cycle pulse at write completion.
- wr_err  out  1  one-cycle pulse together with wr_done on a BUSY_MAX timeout.
- A  out  AW  macro address.
- CEN  out  1  macro chip enable, active low.
- OEN  out  1  macro output enable, active low.
- WEN  out  1  macro write enable, active low; the falling edge latches the data.
- DBI  out  DW  macro write data.
- RD_CLK  out  1  macro read clock; its rising edge loads DBO.
- DBO  in  DW  macro read data.
- READY  in  1  macro write-ready flag; low means programming is in progress.

Behaviour:
- Reset (async, any state): FSM=IDLE; CEN=OEN=WEN=1; RD_CLK=0; A=0; DBI=0; rdata=0; rdata_vld=wr_done=wr_err=busy=0; counter cleared.
- All outputs are registered, so there are no glitches on WEN or RD_CLK.
- States: IDLE, RD_SET, RD_CLK_H, RD_CAP, WR_SET, WR_PULSE, WR_WLOW, WR_WHIGH, WR_END.
- Requests are accepted only in IDLE. Requests seen while busy are ignored; there is no queue.
- Simultaneous req_rd and req_wr in IDLE: write wins, and the read is dropped.
- Read sequence (request sampled at edge N):
  - N: A=req_addr, CEN=0, OEN=0 -> RD_SET.
  - N+1: RD_CLK=1 -> RD_CLK_H.
  - N+2: RD_CLK=0 -> RD_CAP.
  - N+3: rdata<=DBO, rdata_vld=1, CEN=OEN=1 -> IDLE.
  - Read latency is 3 cycles, request to rdata_vld.
- Write sequence (request sampled at edge N):
  - N: A=req_addr, DBI=req_wdata, CEN=0, OEN=1 -> WR_SET.
  - N+1: WEN=0 -> WR_PULSE.
  - N+2: WEN=1, counter cleared -> WR_WLOW.
- WR_WLOW: counter increments each cycle.
  - READY==0 -> clear counter, go to WR_WHIGH.
  - Counter reaches FALL_WIN with READY still 1 -> WR_END, no error.
- WR_WHIGH: counter increments each cycle.
  - READY==1 -> WR_END.
  - Counter reaches BUSY_MAX -> WR_END and flag a timeout.
- WR_END: wr_done=1 for one cycle; wr_err=1 that same cycle only on timeout; CEN=1; A and DBI are held through WR_END; -> IDLE.
- A, DBI and CEN are stable from WR_SET until WR_END; the macro is not re-addressed mid-write.
- The counter is 14 bits and saturates at BUSY_MAX with no wrap-around.
- READY is sampled directly on CLK1D92. The macro updates READY on the same clock, so no synchronizer is needed.
- DBO is treated as valid only in RD_CAP and ignored otherwise.
- Reset during RD_CLK_H forces RD_CLK=0 immediately; reset during a write returns WEN/CEN high immediately.
- CHER, CHWR, PCH, ERFL, OPT, PT, ET, WS, WSEN, ITEST and EXCP are tied at the top level and are not driven here.

Test Plan:
- Reset, then read addr 8 (macro reset content 16'h0301) -> RD_CLK high exactly one cycle at N+1; rdata=16'h0301 with rdata_vld at N+3; busy high for 3 cycles.
- Write addr 40 data 16'hA5A5 -> WEN low exactly one cycle at N+1; READY falls ~301 cycles later; wr_done ~9000 cycles after WEN rise, wr_err=0. A following read of addr 40 returns 16'hA5A5.
- Second write after the macro counter has passed 9000 (READY never falls) -> wr_done at FALL_WIN+1 (512) cycles after WEN rise, wr_err=0.
- Forced READY stuck low -> wr_done and wr_err pulse together after BUSY_MAX (16383) cycles in WR_WHIGH; FSM returns to IDLE.
- req_rd=req_wr=1 in IDLE, then req_rd pulsed while busy -> only the write executes (WEN pulse, no RD_CLK); the busy-time read is ignored.
- RSTN asserted in RD_CLK_H and again in WR_WHIGH -> RD_CLK=0, CEN=OEN=WEN=1, busy=0 immediately; the next read completes normally.
